// File: rtl/rfnoc_null_src_sink_pkg.sv
// rfnoc_null_src_sink_pkg: register map, CHDR header layout and source FSM states
// shared by the null source/sink block and its counters.
package rfnoc_null_src_sink_pkg;
  localparam logic [19:0] REG_CTRL_STATUS       = 20'h00;
  localparam logic [19:0] REG_SRC_LINES_PER_PKT = 20'h04;
  localparam logic [19:0] REG_SRC_BYTES_PER_PKT = 20'h08;
  localparam logic [19:0] REG_SNK_LINE_CNT_LO   = 20'h10;
  localparam logic [19:0] REG_SNK_LINE_CNT_HI   = 20'h14;
  localparam logic [19:0] REG_SNK_PKT_CNT_LO    = 20'h18;
  localparam logic [19:0] REG_SNK_PKT_CNT_HI    = 20'h1C;
  localparam logic [19:0] REG_SRC_LINE_CNT_LO   = 20'h20;
  localparam logic [19:0] REG_SRC_LINE_CNT_HI   = 20'h24;
  localparam logic [19:0] REG_SRC_PKT_CNT_LO    = 20'h28;
  localparam logic [19:0] REG_SRC_PKT_CNT_HI    = 20'h2C;
  localparam logic [19:0] REG_LOOP_LINE_CNT_LO  = 20'h30;
  localparam logic [19:0] REG_LOOP_LINE_CNT_HI  = 20'h34;
  localparam logic [19:0] REG_LOOP_PKT_CNT_LO   = 20'h38;
  localparam logic [19:0] REG_LOOP_PKT_CNT_HI   = 20'h3C;
  localparam logic [11:0] SRC_LINES_RST = 12'hFF;
  localparam logic [15:0] SRC_BYTES_RST = 16'((255 + 2) * 8);
  localparam int HDR_PKT_TYPE_LSB = 53;
  localparam int HDR_SEQ_LSB      = 32;
  localparam int HDR_LEN_LSB      = 16;
  localparam logic [2:0] PKT_TYPE_DATA = 3'd6;
  typedef enum logic [1:0] {SRC_IDLE, SRC_HDR, SRC_DATA} src_state_t;
  function automatic logic [63:0] chdr_hdr(input logic [15:0] seq, input logic [15:0] len);
    logic [63:0] h;
    h = '0;
    h[HDR_PKT_TYPE_LSB +: 3] = PKT_TYPE_DATA;
    h[HDR_SEQ_LSB +: 16] = seq;
    h[HDR_LEN_LSB +: 16] = len;
    return h;
  endfunction
  function automatic logic [63:0] payload_line(input logic [15:0] k);
    return {~k, k, ~k, k};
  endfunction
endpackage

// File: rtl/null_pkt_counter.sv
// null_pkt_counter: 64-bit payload-line and packet counters for one CHDR stream;
// the first beat of each packet (the header) is excluded from the line count.
module null_pkt_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        valid,
  input  logic        ready,
  input  logic        last,
  output logic [63:0] line_cnt,
  output logic [63:0] pkt_cnt
);
  logic sop;
  logic beat;
  assign beat = valid && ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sop      <= 1'b1;
      line_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (beat) sop <= last;
      line_cnt <= clr ? '0 : line_cnt + 64'(beat && !sop);
      pkt_cnt  <= clr ? '0 : pkt_cnt + 64'(beat && last);
    end
  end
endmodule

// File: rtl/rfnoc_block_null_src_sink.sv
// rfnoc_block_null_src_sink: CHDR null sink (port 0 in), packet source (port 0 out),
// combinational loopback (port 1) and ctrlport-readable traffic counters.
module rfnoc_block_null_src_sink
  import rfnoc_null_src_sink_pkg::*;
#(
  parameter int CHDR_W = 64,
  parameter int NIPC   = 2,
  parameter int ITEM_W = 32
) (
  input  logic              rfnoc_chdr_clk,
  input  logic              rfnoc_chdr_rst_n,
  input  logic              s_ctrlport_req_wr,
  input  logic              s_ctrlport_req_rd,
  input  logic [19:0]       s_ctrlport_req_addr,
  input  logic [31:0]       s_ctrlport_req_data,
  output logic              s_ctrlport_resp_ack,
  output logic [31:0]       s_ctrlport_resp_data,
  input  logic [CHDR_W-1:0] s_in0_tdata,
  input  logic              s_in0_tlast,
  input  logic              s_in0_tvalid,
  output logic              s_in0_tready,
  input  logic [CHDR_W-1:0] s_in1_tdata,
  input  logic              s_in1_tlast,
  input  logic              s_in1_tvalid,
  output logic              s_in1_tready,
  output logic [CHDR_W-1:0] m_out0_tdata,
  output logic              m_out0_tlast,
  output logic              m_out0_tvalid,
  input  logic              m_out0_tready,
  output logic [CHDR_W-1:0] m_out1_tdata,
  output logic              m_out1_tlast,
  output logic              m_out1_tvalid,
  input  logic              m_out1_tready
);
  logic        src_en, clr, wr_ctrl, src_hs;
  logic [11:0] lines, beat;
  logic [15:0] bytes, seq, kidx;
  logic [31:0] rd_data;
  logic [63:0] snk_lines, snk_pkts, src_lines, src_pkts, loop_lines, loop_pkts;
  logic        sink_unused;
  src_state_t  state, state_nxt;

  assign sink_unused = ^{s_in0_tdata, s_ctrlport_req_data[31:16]};
  assign wr_ctrl = s_ctrlport_req_wr && s_ctrlport_req_addr == REG_CTRL_STATUS;
  assign clr = wr_ctrl && s_ctrlport_req_data[0];
  assign src_hs = m_out0_tvalid && m_out0_tready;

  assign m_out1_tdata  = s_in1_tdata;
  assign m_out1_tlast  = s_in1_tlast;
  assign m_out1_tvalid = s_in1_tvalid;
  assign s_in1_tready  = m_out1_tready;

  always_comb begin
    rd_data = '0;
    case (s_ctrlport_req_addr)
      REG_CTRL_STATUS:       rd_data = {8'(NIPC), 8'(ITEM_W), 14'b0, src_en, 1'b0};
      REG_SRC_LINES_PER_PKT: rd_data = {20'b0, lines};
      REG_SRC_BYTES_PER_PKT: rd_data = {16'b0, bytes};
      REG_SNK_LINE_CNT_LO:   rd_data = snk_lines[31:0];
      REG_SNK_LINE_CNT_HI:   rd_data = snk_lines[63:32];
      REG_SNK_PKT_CNT_LO:    rd_data = snk_pkts[31:0];
      REG_SNK_PKT_CNT_HI:    rd_data = snk_pkts[63:32];
      REG_SRC_LINE_CNT_LO:   rd_data = src_lines[31:0];
      REG_SRC_LINE_CNT_HI:   rd_data = src_lines[63:32];
      REG_SRC_PKT_CNT_LO:    rd_data = src_pkts[31:0];
      REG_SRC_PKT_CNT_HI:    rd_data = src_pkts[63:32];
      REG_LOOP_LINE_CNT_LO:  rd_data = loop_lines[31:0];
      REG_LOOP_LINE_CNT_HI:  rd_data = loop_lines[63:32];
      REG_LOOP_PKT_CNT_LO:   rd_data = loop_pkts[31:0];
      REG_LOOP_PKT_CNT_HI:   rd_data = loop_pkts[63:32];
      default:               rd_data = '0;
    endcase
  end

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
      s_in0_tready         <= 1'b0;
      src_en               <= 1'b0;
      lines                <= SRC_LINES_RST;
      bytes                <= SRC_BYTES_RST;
    end else begin
      s_ctrlport_resp_ack  <= s_ctrlport_req_wr || s_ctrlport_req_rd;
      s_ctrlport_resp_data <= s_ctrlport_req_rd ? rd_data : '0;
      s_in0_tready         <= 1'b1;
      if (wr_ctrl) src_en <= s_ctrlport_req_data[1];
      if (s_ctrlport_req_wr && s_ctrlport_req_addr == REG_SRC_LINES_PER_PKT) lines <= s_ctrlport_req_data[11:0];
      if (s_ctrlport_req_wr && s_ctrlport_req_addr == REG_SRC_BYTES_PER_PKT) bytes <= s_ctrlport_req_data[15:0];
    end
  end

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) state <= SRC_IDLE;
    else state <= state_nxt;
  end

  // Leaving DATA only on the final-line handshake lets a cleared src_en finish the packet.
  always_comb begin
    state_nxt = state == SRC_IDLE ? (src_en ? SRC_HDR : SRC_IDLE) :
                state == SRC_HDR  ? (src_hs ? SRC_DATA : SRC_HDR) :
                (src_hs && m_out0_tlast) ? (src_en ? SRC_HDR : SRC_IDLE) : SRC_DATA;
  end

  always_comb begin
    m_out0_tvalid = state != SRC_IDLE;
    m_out0_tlast  = state == SRC_DATA && beat == lines;
    m_out0_tdata  = state == SRC_HDR ? chdr_hdr(seq, bytes) : payload_line(kidx);
  end

  always_ff @(posedge rfnoc_chdr_clk or negedge rfnoc_chdr_rst_n) begin
    if (!rfnoc_chdr_rst_n) begin
      beat <= '0;
      seq  <= '0;
      kidx <= '0;
    end else begin
      if (src_hs) beat <= state == SRC_HDR ? '0 : beat + 12'd1;
      seq  <= clr ? '0 : seq + 16'(src_hs && m_out0_tlast);
      kidx <= clr ? '0 : kidx + 16'(src_hs && state == SRC_DATA);
    end
  end

  null_pkt_counter u_snk_cnt (
    .clk(rfnoc_chdr_clk), .rst_n(rfnoc_chdr_rst_n), .clr(clr),
    .valid(s_in0_tvalid), .ready(s_in0_tready), .last(s_in0_tlast),
    .line_cnt(snk_lines), .pkt_cnt(snk_pkts)
  );
  null_pkt_counter u_src_cnt (
    .clk(rfnoc_chdr_clk), .rst_n(rfnoc_chdr_rst_n), .clr(clr),
    .valid(m_out0_tvalid), .ready(m_out0_tready), .last(m_out0_tlast),
    .line_cnt(src_lines), .pkt_cnt(src_pkts)
  );
  null_pkt_counter u_loop_cnt (
    .clk(rfnoc_chdr_clk), .rst_n(rfnoc_chdr_rst_n), .clr(clr),
    .valid(s_in1_tvalid), .ready(s_in1_tready), .last(s_in1_tlast),
    .line_cnt(loop_lines), .pkt_cnt(loop_pkts)
  );
endmodule

// File: tb/tb_rfnoc_block_null_src_sink.sv
// tb_rfnoc_block_null_src_sink: randomized traffic with scoreboarded ctrlport reads,
// loopback beats and a source-stream reference model.
module tb_rfnoc_block_null_src_sink;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_wr, req_rd, resp_ack;
  logic [19:0] req_addr;
  logic [31:0] req_data, resp_data;
  logic [63:0] s_in0_tdata, s_in1_tdata, m_out0_tdata, m_out1_tdata;
  logic        s_in0_tlast, s_in0_tvalid, s_in0_tready;
  logic        s_in1_tlast, s_in1_tvalid, s_in1_tready;
  logic        m_out0_tlast, m_out0_tvalid, m_out0_tready;
  logic        m_out1_tlast, m_out1_tvalid, m_out1_tready;

  always #5 clk = ~clk;

  rfnoc_block_null_src_sink #(.CHDR_W(64), .NIPC(2), .ITEM_W(32)) dut (
    .rfnoc_chdr_clk(clk), .rfnoc_chdr_rst_n(rst_n),
    .s_ctrlport_req_wr(req_wr), .s_ctrlport_req_rd(req_rd),
    .s_ctrlport_req_addr(req_addr), .s_ctrlport_req_data(req_data),
    .s_ctrlport_resp_ack(resp_ack), .s_ctrlport_resp_data(resp_data),
    .s_in0_tdata(s_in0_tdata), .s_in0_tlast(s_in0_tlast), .s_in0_tvalid(s_in0_tvalid), .s_in0_tready(s_in0_tready),
    .s_in1_tdata(s_in1_tdata), .s_in1_tlast(s_in1_tlast), .s_in1_tvalid(s_in1_tvalid), .s_in1_tready(s_in1_tready),
    .m_out0_tdata(m_out0_tdata), .m_out0_tlast(m_out0_tlast), .m_out0_tvalid(m_out0_tvalid), .m_out0_tready(m_out0_tready),
    .m_out1_tdata(m_out1_tdata), .m_out1_tlast(m_out1_tlast), .m_out1_tvalid(m_out1_tvalid), .m_out1_tready(m_out1_tready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {bit is_rd; logic [19:0] addr; logic [31:0] exp;} rq_t;
  typedef struct {logic [63:0] d; logic l;} beat_t;
  rq_t   rq[$];
  beat_t loop_q[$];

  logic [63:0] loop_lines = 0, loop_pkts = 0, snk_lines = 0, snk_pkts = 0;
  logic [63:0] src_lines = 0, src_pkts = 0;
  logic [15:0] src_seq = 0, src_k = 0, src_bytes = 16'd2056;
  int          src_nl = 255;
  int          src_pos = 0;
  logic        strobe_d = 1'b0;
  bit          stall0 = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired before the DUT responded", name);
  endtask

  task automatic ctrl(input bit rd, input logic [19:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_wr = !rd; req_rd = rd; req_addr = a; req_data = rd ? 32'h0 : d;
    rq.push_back('{rd, a, d});
    @(posedge clk); #1;
    req_wr = 0; req_rd = 0;
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    ctrl(0, a, d);
  endtask

  task automatic rd(input logic [19:0] a, input logic [31:0] exp);
    ctrl(1, a, exp);
  endtask

  task automatic rd64(input logic [19:0] a, input logic [63:0] exp);
    rd(a, exp[31:0]);
    rd(a + 20'h4, exp[63:32]);
  endtask

  task automatic send(input bit port, input int npkt, input int nl);
    for (int p = 0; p < npkt; p++) begin
      for (int b = 0; b <= nl; b++) begin
        logic [63:0] d;
        bit hs;
        int t;
        d = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin
          s_in0_tvalid = 0; s_in1_tvalid = 0;
          @(posedge clk); #1;
        end
        if (port) begin
          s_in1_tvalid = 1; s_in1_tdata = d; s_in1_tlast = (b == nl);
          loop_q.push_back('{d, (b == nl)});
        end else begin
          s_in0_tvalid = 1; s_in0_tdata = d; s_in0_tlast = (b == nl);
        end
        hs = 0; t = 0;
        while (!hs && t < 200) begin
          @(negedge clk);
          hs = port ? s_in1_tready : s_in0_tready;
          @(posedge clk); #1;
          t++;
        end
        if (!hs) timeout("send_handshake");
      end
    end
    s_in0_tvalid = 0; s_in1_tvalid = 0;
    if (port) begin
      loop_lines += 64'(npkt * nl); loop_pkts += 64'(npkt);
    end else begin
      snk_lines += 64'(npkt * nl); snk_pkts += 64'(npkt);
    end
  endtask

  task automatic wait_src_idle();
    bit done;
    int seen;
    done = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      @(negedge clk);
      done = !m_out0_tvalid;
    end
    if (!done) timeout("src_idle");
    check("src_packet_boundary", 64'(src_pos), 64'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (m_out0_tvalid) seen++;
    end
    check("src_no_more_pkts", 64'(seen), 64'd0);
  endtask

  task automatic rd_all_counters();
    rd64(20'h10, snk_lines);  rd64(20'h18, snk_pkts);
    rd64(20'h20, src_lines);  rd64(20'h28, src_pkts);
    rd64(20'h30, loop_lines); rd64(20'h38, loop_pkts);
  endtask

  // Output readies: port 1 always random, port 0 random unless deliberately stalled.
  initial begin
    m_out0_tready = 0; m_out1_tready = 0;
    forever begin
      @(posedge clk); #1;
      m_out0_tready = stall0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      m_out1_tready = $urandom_range(0, 3) != 0;
    end
  end

  initial forever begin
    @(posedge clk);
    strobe_d = req_wr || req_rd;
  end

  // Ctrlport monitor: one ack per strobe, read data against the queued expectation.
  initial forever begin
    @(negedge clk);
    if (rst_n && (resp_ack || strobe_d)) begin
      check("resp_ack_timing", 64'(resp_ack), 64'(strobe_d));
      if (resp_ack) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_ack: got ack with no outstanding request, required none");
        end else begin
          rq_t r;
          r = rq.pop_front();
          if (r.is_rd) check($sformatf("rd_%02h", r.addr), 64'(resp_data), 64'(r.exp));
        end
      end
    end
  end

  // Loopback monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n && m_out1_tvalid) begin
      check("loop_tready", 64'(s_in1_tready), 64'(m_out1_tready));
      if (m_out1_tready) begin
        if (loop_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL loop_beat: got unexpected beat %h, required none", m_out1_tdata);
        end else begin
          beat_t e;
          e = loop_q.pop_front();
          check("loop_tdata", m_out1_tdata, e.d);
          check("loop_tlast", 64'(m_out1_tlast), 64'(e.l));
        end
      end
    end
  end

  // Source monitor: header/payload model plus hold-under-backpressure check.
  initial begin
    bit          stalled;
    logic [63:0] held_d;
    logic        held_l;
    logic [63:0] exp_d;
    stalled = 0; held_d = 0; held_l = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stalled) begin
          check("src_hold_valid", 64'(m_out0_tvalid), 64'd1);
          check("src_hold_data", m_out0_tdata, held_d);
          check("src_hold_last", 64'(m_out0_tlast), 64'(held_l));
        end
        stalled = m_out0_tvalid && !m_out0_tready;
        held_d = m_out0_tdata; held_l = m_out0_tlast;
        if (m_out0_tvalid && m_out0_tready) begin
          exp_d = src_pos == 0 ? {6'd0, 2'd0, 3'd6, 5'd0, src_seq, src_bytes, 16'd0}
                               : {~src_k, src_k, ~src_k, src_k};
          check(src_pos == 0 ? "src_header" : "src_payload", m_out0_tdata, exp_d);
          check("src_tlast", 64'(m_out0_tlast), 64'(src_pos == src_nl + 1));
          if (src_pos != 0) src_k++;
          if (src_pos == src_nl + 1) begin
            src_pos = 0; src_seq++; src_pkts++;
            src_lines += 64'(src_nl + 1);
          end else src_pos++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req_wr = 0; req_rd = 0; req_addr = 0; req_data = 0;
    s_in0_tdata = 0; s_in0_tlast = 0; s_in0_tvalid = 0;
    s_in1_tdata = 0; s_in1_tlast = 0; s_in1_tvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_in0_tready", 64'(s_in0_tready), 64'd0);
    check("rst_resp_ack", 64'(resp_ack), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_m_out0_tvalid", 64'(m_out0_tvalid), 64'd0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("s_in0_tready_after_rst", 64'(s_in0_tready), 64'd1);

    rd(20'h00, 32'h0220_0000);
    rd(20'h04, 32'h0000_00FF);
    rd(20'h08, 32'd2056);
    rd(20'h0C, 32'h0);
    wr(20'h10, 32'hDEAD_BEEF);
    rd(20'h10, 32'h0);

    send(1, 50, 101);
    repeat (5) @(posedge clk);
    check("loop_q_drained", 64'(loop_q.size()), 64'd0);
    rd_all_counters();

    send(0, 50, 101);
    rd_all_counters();

    wr(20'h04, 32'd100); src_nl = 100;
    wr(20'h08, 32'd816); src_bytes = 16'd816;
    rd(20'h04, 32'd100);
    rd(20'h08, 32'd816);
    wr(20'h00, 32'h2);
    rd(20'h00, 32'h0220_0002);
    repeat (2000) @(posedge clk);
    wr(20'h00, 32'h0);
    wait_src_idle();
    rd_all_counters();

    wr(20'h00, 32'h2);
    begin
      bit mid;
      mid = 0;
      for (int t = 0; t < 5000 && !mid; t++) begin
        @(negedge clk);
        mid = src_pos >= 50 && src_pos < 90;
      end
      if (!mid) timeout("src_mid_packet");
    end
    stall0 = 1;
    wr(20'h00, 32'h0);
    repeat (10) @(negedge clk);
    check("src_stalled_valid", 64'(m_out0_tvalid), 64'd1);
    stall0 = 0;
    wait_src_idle();
    rd_all_counters();

    wr(20'h00, 32'h1);
    src_seq = 0; src_k = 0;
    loop_lines = 0; loop_pkts = 0; snk_lines = 0; snk_pkts = 0; src_lines = 0; src_pkts = 0;
    rd_all_counters();

    wr(20'h04, 32'd3); src_nl = 3;
    wr(20'h00, 32'h2);
    repeat (40) @(posedge clk);
    wr(20'h00, 32'h0);
    wait_src_idle();
    rd_all_counters();

    begin
      bit empty;
      empty = 0;
      for (int t = 0; t < 100 && !empty; t++) begin
        @(negedge clk);
        empty = rq.size() == 0;
      end
      if (!empty) timeout("ctrl_drain");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rfnoc_block_null_src_sink.md
RFNOC_BLOCK_NULL_SRC_SINK -- requirements
Module: rfnoc_block_null_src_sink

Interface
REQ-001 Parameter CHDR_W, default 64: CHDR data width in bits; only 64 is supported.
REQ-002 Parameter NIPC, default 2: items per CHDR line, reported in the status register.
REQ-003 Parameter ITEM_W, default 32: item width in bits, reported in the status register.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 rfnoc_chdr_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rfnoc_chdr_rst_n  in  1  asynchronous active-low reset.
REQ-007 s_ctrlport_req_wr, s_ctrlport_req_rd  in  1 each  register write / read strobe, one cycle each.
REQ-008 s_ctrlport_req_addr  in  20  byte address; s_ctrlport_req_data  in  32  write data.
REQ-009 s_ctrlport_resp_ack  out  1; s_ctrlport_resp_data  out  32  read data.
REQ-010 s_in{0,1}_tdata/tlast/tvalid/tready  in/in/in/out  CHDR_W/1/1/1  input CHDR streams; port 0 is sink, port 1 is loopback.
REQ-011 m_out{0,1}_tdata/tlast/tvalid/tready  out/out/out/in  CHDR_W/1/1/1  output CHDR streams; port 0 is source, port 1 is loopback.

Function
REQ-012 Registers: CTRL_STATUS 0x00, SRC_LINES_PER_PKT 0x04, SRC_BYTES_PER_PKT 0x08, SNK_LINE_CNT_LO/HI 0x10/0x14, SNK_PKT_CNT_LO/HI 0x18/0x1C, SRC_LINE_CNT_LO/HI 0x20/0x24, SRC_PKT_CNT_LO/HI 0x28/0x2C, LOOP_LINE_CNT_LO/HI 0x30/0x34, LOOP_PKT_CNT_LO/HI 0x38/0x3C.
REQ-013 resp_ack SHALL pulse exactly 1 cycle after every rd or wr strobe; read data is valid in the ack cycle; unmapped reads return 0; writes to read-only registers are ignored.
REQ-014 CTRL_STATUS write: bit0 = clear all counters (self-clearing pulse); bit1 = src_en (held).
REQ-015 CTRL_STATUS read: [31:24]=NIPC, [23:16]=ITEM_W, [1]=src_en, all other bits 0.
REQ-016 SRC_LINES_PER_PKT [11:0] = N; each source packet carries N+1 payload lines; the register is read/write.
REQ-017 SRC_BYTES_PER_PKT [15:0] is the CHDR header length field (header included); the register is read/write.
REQ-018 Sink port: s_in0_tready is held at 1 whenever out of reset; all data is discarded.
REQ-019 Loopback port: s_in1 is passed combinationally to m_out1 (tdata, tlast, tvalid forward; tready back); zero latency, no buffering.
REQ-020 Line counters (64-bit) count handshaked beats that are not the first beat of a packet, i.e. payload lines only; the header is excluded.
REQ-021 Packet counters (64-bit) increment on each handshaked beat with tlast=1.
REQ-022 Sink counters use s_in0 handshakes; loop counters use s_in1 handshakes; source counters use m_out0 handshakes.
REQ-023 Source state machine states are IDLE, HDR and DATA.
REQ-024 IDLE→HDR occurs when src_en=1.
REQ-025 HDR emits one header beat, then moves to DATA.
REQ-026 DATA emits N+1 payload lines, tlast on the final line, then goes to HDR if src_en=1, else IDLE.
REQ-027 Clearing src_en mid-packet SHALL complete the current packet.
REQ-028 Header fields: [63:58]=0, [57:56]=0, [55:53]=3'd6, [52:48]=0, [47:32]=seq_num (incrementing per packet, wraps at 16 bits), [31:16]=SRC_BYTES_PER_PKT, [15:0]=0.
REQ-029 Payload line k, where k is a running 16-bit line index across packets starting at 0, SHALL be {~k[15:0], k[15:0], ~k[15:0], k[15:0]}; k wraps at 16 bits.
REQ-030 m_out0_tvalid is held until tready; outputs are stable while tvalid=1 and tready=0.
REQ-031 The clear pulse resets all six counters, seq_num and the line index k in the following cycle.
REQ-032 When a clear and an increment coincide, clear wins.
REQ-033 Counters SHALL wrap at 2^64.

Reset
REQ-034 On rfnoc_chdr_rst_n=0: all counters 0, src_en 0, source FSM in IDLE, seq_num and k 0, m_out0_tvalid 0, resp_ack 0, resp_data 0; s_in0_tready 0 while in reset.
REQ-035 On reset: SRC_LINES_PER_PKT=0xFF, SRC_BYTES_PER_PKT=(0xFF+2)*8.

Structure
REQ-036 Register offsets, CHDR header field positions and the DATA pkt_type constant SHALL reside in shared package rfnoc_null_src_sink_pkg.
REQ-037 One sub-module, null_pkt_counter, SHALL hold each 64-bit line/packet counter pair with its first-beat tracking; it is instantiated three times.

Verification
REQ-038 Read CTRL_STATUS after reset -> [31:24]=2, [23:16]=32, bit1=0.
REQ-039 Send 50 packets of 101 payload lines plus a header to port 1 -> identical data on m_out1; LOOP_LINE_CNT_LO=5050, LOOP_PKT_CNT_LO=50; SRC and SNK counts 0.
REQ-040 Send 50 packets of 101 payload lines plus a header to port 0 -> SNK_LINE_CNT_LO=5050, SNK_PKT_CNT_LO=50; loop counts unchanged.
REQ-041 Write LINES_PER_PKT=100, BYTES_PER_PKT=816, set src_en, later clear it -> whole packets of 102 beats, header length 816, payload pattern with k continuous across packets, seq_num 0,1,2,...
REQ-042 Clear src_en while m_out0_tready is held low mid-packet -> the packet completes after tready rises, and no further packets follow.
REQ-043 Write CTRL_STATUS=1 -> all twelve counter registers read 0.
